// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx
//   Accepts a WIDTH-bit word via ready/load and shifts it out MSB-first,
//   one bit per clock, tracking the running prefix value mod 3. At end of
//   word a one-cycle done pulse reports whether the word is divisible by 3.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   load      accept request, honoured only while ready=1
//   data      word to send, sampled on the accepting edge
//   ready     idle, will accept load
//   outp      current serial bit (0 outside SHIFT)
//   out_valid outp carries a valid bit
//   last      outp is the LSB of the word
//   residue   prefix mod 3 including the bit on outp
//   done      one-cycle pulse after the last bit
//   div3      valid with done; 1 when word mod 3 == 0
module mod3_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             outp,
  output logic             out_valid,
  output logic             last,
  output logic [1:0]       residue,
  output logic             done,
  output logic             div3
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             ready_q, ready_d;
  logic             outp_q, outp_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic [1:0]       residue_q, residue_d;
  logic             done_q, done_d;
  logic             div3_q, div3_d;

  // (2r + b) mod 3 as a table on {r, b}; 2'b11 is never reached
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    outp_d      = 1'b0;
    out_valid_d = 1'b0;
    last_d      = 1'b0;
    residue_d   = residue_q;
    done_d      = 1'b0;
    div3_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d     = S_SHIFT;
          // MSB goes straight to outp, so the register holds the remaining bits
          shreg_d     = data << 1;
          outp_d      = data[WIDTH-1];
          out_valid_d = 1'b1;
          residue_d   = {1'b0, data[WIDTH-1]};
          cnt_d       = CW'(1);
          last_d      = (WIDTH == 1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          div3_d  = (residue_q == 2'd0);
          cnt_d   = '0;
        end else begin
          outp_d      = shreg_q[WIDTH-1];
          shreg_d     = shreg_q << 1;
          out_valid_d = 1'b1;
          residue_d   = mod3_step(residue_q, shreg_q[WIDTH-1]);
          cnt_d       = cnt_inc;
          last_d      = (cnt_inc == CW'(WIDTH));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      residue_q   <= 2'd0;
      done_q      <= 1'b0;
      div3_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      residue_q   <= residue_d;
      done_q      <= done_d;
      div3_q      <= div3_d;
    end
  end

  assign ready     = ready_q;
  assign outp      = outp_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign residue   = residue_q;
  assign done      = done_q;
  assign div3      = div3_q;

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Scoreboard bench for mod3_serial_tx: one WIDTH=8 and one WIDTH=1 instance.
// Accepted words are expanded into expected bit/word records from plain
// arithmetic (prefix value % 3); a negedge monitor pops and compares them.
module tb_mod3_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load8, load1;
  logic [7:0] data8;
  logic [0:0] data1;
  logic       ready8, outp8, ov8, last8, done8, div3_8;
  logic [1:0] res8;
  logic       ready1, outp1, ov1, last1, done1, div3_1;
  logic [1:0] res1;

  mod3_serial_tx #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .load(load8), .data(data8),
    .ready(ready8), .outp(outp8), .out_valid(ov8), .last(last8),
    .residue(res8), .done(done8), .div3(div3_8)
  );

  mod3_serial_tx #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .load(load1), .data(data1),
    .ready(ready1), .outp(outp1), .out_valid(ov1), .last(last1),
    .residue(res1), .done(done1), .div3(div3_1)
  );

  typedef struct { logic b; logic [1:0] r; logic l; int c; } bit_t;
  typedef struct { logic d3; int c; } word_t;

  bit_t  bq8[$], bq1[$];
  word_t wq8[$], wq1[$];

  int cyc = 0;
  int checks = 0, errors = 0;
  int acc8_n = 0, acc8_cyc = 0, acc8_prev = 0;
  int acc1_n = 0, acc1_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d", name, cyc);
  endtask

  // Reference model: bit k of a w-bit word d appears k+1 cycles after the
  // accept, carrying (d >> (w-1-k)) % 3; done follows w+1 cycles after accept.
  function automatic void push(input int id, input int w, input logic [31:0] d, input int c);
    bit_t e;
    word_t we;
    logic [31:0] pre;
    for (int k = 0; k < w; k++) begin
      pre = d >> (w - 1 - k);
      e.b = pre[0];
      e.r = 2'(pre % 3);
      e.l = (k == w - 1);
      e.c = c + 1 + k;
      if (id == 0) bq8.push_back(e); else bq1.push_back(e);
    end
    we.d3 = ((d % 3) == 0);
    we.c  = c + 1 + w;
    if (id == 0) wq8.push_back(we); else wq1.push_back(we);
  endfunction

  // Accept tracker: a word is taken on an edge where ready=1 and load=1
  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        if (load8 && ready8) begin
          push(0, 8, {24'b0, data8}, cyc);
          acc8_n++;
          acc8_prev = acc8_cyc;
          acc8_cyc  = cyc;
        end
        if (load1 && ready1) begin
          push(1, 1, {31'b0, data1}, cyc);
          acc1_n++;
          acc1_cyc = cyc;
        end
      end
      cyc++;
    end
  end

  task automatic mon(input int id, input logic ov, input logic o, input logic l,
                     input logic [1:0] r, input logic dn, input logic d3, input logic rdy);
    bit_t e;
    word_t we;
    string p;
    p = (id == 0) ? "w8" : "w1";
    if (ov) begin
      if ((id == 0 && bq8.size() == 0) || (id == 1 && bq1.size() == 0))
        fail({p, " unexpected out_valid"});
      else begin
        e = (id == 0) ? bq8.pop_front() : bq1.pop_front();
        chk({p, " outp"}, {31'b0, o}, {31'b0, e.b});
        chk({p, " residue"}, {30'b0, r}, {30'b0, e.r});
        chk({p, " last"}, {31'b0, l}, {31'b0, e.l});
        chk({p, " bit cycle"}, cyc, e.c);
      end
    end else begin
      chk({p, " outp idle"}, {31'b0, o}, 32'd0);
      chk({p, " last idle"}, {31'b0, l}, 32'd0);
    end
    if (dn) begin
      if ((id == 0 && wq8.size() == 0) || (id == 1 && wq1.size() == 0))
        fail({p, " unexpected done"});
      else begin
        we = (id == 0) ? wq8.pop_front() : wq1.pop_front();
        chk({p, " div3"}, {31'b0, d3}, {31'b0, we.d3});
        chk({p, " done cycle"}, cyc, we.c);
      end
    end else begin
      chk({p, " div3 outside done"}, {31'b0, d3}, 32'd0);
    end
    chk({p, " ready"}, {31'b0, rdy}, {31'b0, !(ov || dn)});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon(0, ov8, outp8, last8, res8, done8, div3_8, ready8);
        mon(1, ov1, outp1, last1, res1, done1, div3_1, ready1);
      end
    end
  end

  task automatic reset_outputs(input string tag);
    chk({tag, " ready8"}, {31'b0, ready8}, 32'd1);
    chk({tag, " outs8"}, {26'b0, outp8, ov8, last8, res8, done8 | div3_8}, 32'd0);
    chk({tag, " ready1"}, {31'b0, ready1}, 32'd1);
    chk({tag, " outs1"}, {26'b0, outp1, ov1, last1, res1, done1 | div3_1}, 32'd0);
  endtask

  task automatic send8(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!ready8 && n < 50) begin @(negedge clk); n++; end
    if (!ready8) fail("send8 ready timeout");
    else begin
      data8 = d; load8 = 1'b1;
      @(negedge clk);
      load8 = 1'b0;
    end
  endtask

  task automatic send1(input logic d);
    int n = 0;
    @(negedge clk);
    while (!ready1 && n < 50) begin @(negedge clk); n++; end
    if (!ready1) fail("send1 ready timeout");
    else begin
      data1 = d; load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready8 && ready1 && bq8.size() == 0 && wq8.size() == 0 &&
             bq1.size() == 0 && wq1.size() == 0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) fail("wait_idle timeout");
  endtask

  initial begin
    int rel, n0, n;
    rst = 1'b1; load8 = 1'b0; load1 = 1'b0; data8 = '0; data1 = '0;
    #1 rst = 1'b0;
    load8 = 1'b1; data8 = 8'd90;
    load1 = 1'b1; data1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      reset_outputs("reset");
    end
    rel = cyc;
    rst = 1'b1;
    @(negedge clk);
    load8 = 1'b0; load1 = 1'b0;
    chk("w8 accept at first edge", acc8_cyc, rel);
    chk("w8 accept count", acc8_n, 1);
    chk("w1 accept at first edge", acc1_cyc, rel);
    wait_idle();

    send8(8'd7);
    send1(1'b0);
    wait_idle();

    // back-to-back with load held; data change during SHIFT must be ignored
    @(negedge clk);
    n0 = acc8_n;
    data8 = 8'hFF; load8 = 1'b1;
    repeat (3) @(negedge clk);
    data8 = 8'h01;
    n = 0;
    while (acc8_n < n0 + 2 && n < 50) begin @(negedge clk); n++; end
    load8 = 1'b0;
    if (acc8_n < n0 + 2) fail("b2b second accept timeout");
    else chk("b2b accept spacing", acc8_cyc - acc8_prev, 10);
    wait_idle();

    // asynchronous reset while bit 4 of 8'h5A is on outp
    send8(8'h5A);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_outputs("midreset");
    bq8.delete(); wq8.delete(); bq1.delete(); wq1.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    send8(8'h03);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send8(8'($urandom));
    end
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send1(1'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("w8 queues drained", bq8.size() + wq8.size(), 0);
    chk("w1 queues drained", bq1.size() + wq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
